// File: rtl/tensor_core_instruction_arbiter.sv
// Round-robin arbiter with burst locking for the shared 16-bit tensor core instruction bus.
// Registers the granted word onto the bus and steers read-back bytes to the requester that issued the read.
module tensor_core_instruction_arbiter #(
  parameter int NUM_REQUESTERS = 2,
  parameter int READ_LATENCY   = 1
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic [NUM_REQUESTERS-1:0]    request_valid,
  input  logic [16*NUM_REQUESTERS-1:0] request_instruction,
  input  logic [NUM_REQUESTERS-1:0]    request_last,
  input  logic [NUM_REQUESTERS-1:0]    request_expects_read,
  output logic [NUM_REQUESTERS-1:0]    request_ready,
  input  logic signed [7:0]            tensor_core_controller_output,
  output logic [15:0]                  current_tensor_core_instruction,
  output logic [NUM_REQUESTERS-1:0]    response_valid,
  output logic signed [7:0]            response_data,
  output logic [1:0]                   lock_owner,
  output logic                         busy
);

  // Handshake: requester k's word transfers in a cycle where request_valid[k] and
  // request_ready[k] are both high; ready never depends on the offered word itself.
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 owner_q, owner_d;
  logic [1:0]                 rr_q, rr_d;
  logic [15:0]                instr_q, instr_d;
  logic [READ_LATENCY:0]      tag_rd_q, tag_rd_d;
  logic [READ_LATENCY:0][1:0] tag_idx_q, tag_idx_d;

  logic [3:0]  valid_ext, last_ext, rd_ext;
  logic [63:0] instr_ext;
  logic        win_found;
  logic [1:0]  win_idx;
  logic [2:0]  cand;
  logic        grant_en;
  logic [1:0]  grant_idx;
  logic        accept, acc_last, acc_rd, bus_is_reset;
  logic [15:0] acc_word;

  assign valid_ext = 4'(request_valid);
  assign last_ext  = 4'(request_last);
  assign rd_ext    = 4'(request_expects_read);
  assign instr_ext = 64'(request_instruction);

  // First valid requester at or after rr_q, wrapping explicitly at NUM_REQUESTERS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 3'd0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand = {1'b0, rr_q} + 3'(i);
      if (cand >= 3'(NUM_REQUESTERS)) cand = cand - 3'(NUM_REQUESTERS);
      if (!win_found && valid_ext[cand[1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end

  assign accept       = grant_en & valid_ext[grant_idx];
  assign acc_last     = last_ext[grant_idx];
  assign acc_rd       = rd_ext[grant_idx];
  assign acc_word     = instr_ext[{grant_idx, 4'b0000} +: 16];
  assign bus_is_reset = (instr_q[1:0] == 2'b11);

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      owner_q   <= 2'd0;
      rr_q      <= 2'd0;
      instr_q   <= 16'h0000;
      tag_rd_q  <= '0;
      tag_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      instr_q   <= instr_d;
      tag_rd_q  <= tag_rd_d;
      tag_idx_q <= tag_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    instr_d = accept ? acc_word : 16'h0000;
    if (accept) begin
      if (acc_last) begin
        state_d = IDLE;
        rr_d    = (grant_idx == 2'(NUM_REQUESTERS - 1)) ? 2'd0 : grant_idx + 2'd1;
      end else if (state_q == IDLE) begin
        state_d = LOCKED;
        owner_d = grant_idx;
      end
    end
    // A reset opcode never returns data, and once on the bus it kills older reads.
    tag_rd_d[0]  = accept && acc_rd && (acc_word[1:0] != 2'b11);
    tag_idx_d[0] = accept ? grant_idx : 2'd0;
    for (int s = 1; s <= READ_LATENCY; s++) begin
      tag_rd_d[s]  = bus_is_reset ? 1'b0 : tag_rd_q[s-1];
      tag_idx_d[s] = bus_is_reset ? 2'd0 : tag_idx_q[s-1];
    end
  end

  always_comb begin
    grant_en  = 1'b0;
    grant_idx = 2'd0;
    if (!reset_in) begin
      if (state_q == LOCKED) begin
        grant_en  = 1'b1;
        grant_idx = owner_q;
      end else begin
        grant_en  = win_found;
        grant_idx = win_idx;
      end
    end
    request_ready  = '0;
    response_valid = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      request_ready[i]  = grant_en && (grant_idx == 2'(i));
      response_valid[i] = tag_rd_q[READ_LATENCY] && (tag_idx_q[READ_LATENCY] == 2'(i));
    end
    lock_owner = (state_q == LOCKED) ? owner_q : 2'd0;
    busy       = (state_q == LOCKED) || (|tag_rd_q);
  end

  assign current_tensor_core_instruction = instr_q;
  assign response_data                   = tensor_core_controller_output;

endmodule

// File: doc/tensor_core_instruction_arbiter.md
# tensor_core_instruction_arbiter

Shares the single 16-bit tensor core instruction bus between several instruction sources, such as the machine-code sequencer and a host loader. Uses round-robin arbitration with burst locking. The block registers the selected word onto the bus and routes the tensor core's 8-bit read-back data to whichever requester issued the read. It sits between the requesters and the tensor core controller, in place of a direct instruction connection.

## Interface
- NUM_REQUESTERS, 2, number of requester ports (legal 2..4)
- READ_LATENCY, 1, cycles from a read instruction appearing on current_tensor_core_instruction to its result on tensor_core_controller_output (legal 1..4)
- clock_in  input  1  sole clock, all state on posedge
- reset_in  input  1  reset, asynchronous, active-high
- request_valid  input  NUM_REQUESTERS  requester k has a word offered
- request_instruction  input  16*NUM_REQUESTERS  word of requester k in bits [16k+15:16k]
- request_last  input  NUM_REQUESTERS  offered word ends requester k's burst
- request_expects_read  input  NUM_REQUESTERS  offered word makes the tensor core return one byte
- request_ready  output  NUM_REQUESTERS  word of requester k accepted this cycle when valid also high
- tensor_core_controller_output  input  8 signed  tensor core read-back byte
- current_tensor_core_instruction  output  16  registered instruction to tensor core; 0 = NOP
- response_valid  output  NUM_REQUESTERS  one-hot; response_data belongs to requester k
- response_data  output  8 signed  combinational copy of tensor_core_controller_output
- lock_owner  output  2  index of current grant owner; 0 when idle
- busy  output  1  burst locked or any read outstanding

## Operation
- State machine has two states, IDLE and LOCKED. A round-robin pointer rr_pointer has range 0..NUM_REQUESTERS-1.
- **IDLE grant:**
  - Winner is the first k with request_valid[k], scanning from rr_pointer upward and wrapping at NUM_REQUESTERS.
  - request_ready is one-hot to the winner, combinational. All-zero when no valid request.
- **LOCKED grant:**
  - request_ready[owner] = 1 and all other bits are 0, regardless of their valids.
  - If the owner drops valid, a NOP is issued (bubble) and the lock is held.
- **Accept rules:**
  - Accept = valid & ready for the granted k. Its word is registered into current_tensor_core_instruction.
  - Any cycle without an accept registers 0 (NOP).
- **Transitions:**
  - IDLE: accept with last=0 → LOCKED with owner=k; accept with last=1 → stay IDLE.
  - LOCKED: accept with last=1 → IDLE.
  - Every last=1 accept sets rr_pointer = (k+1) mod NUM_REQUESTERS. Wrap is explicit; no power-of-two assumption.
- **Read routing:**
  - A tag pipeline of READ_LATENCY+1 stages carries {expects_read, k}.
  - Stage 0 is loaded alongside current_tensor_core_instruction.
  - response_valid[k] = 1 when the final stage holds expects_read=1 with index k.
- **Reset opcode:**
  - An accepted word with bits [1:0]=2'b11 sets the same cycle's stage-0 expects_read to 0.
  - On the cycle it is presented on the bus, all tag stages beyond stage 0 are cleared. Outstanding reads are dropped because the tensor core discards them.
- busy = (state==LOCKED) | OR of all tag-stage expects_read bits.

## Timing
- **Reset values:** while reset_in is high, and immediately on assertion (asynchronous):
  - state IDLE, rr_pointer 0, all tags cleared.
  - current_tensor_core_instruction 0, response_valid 0, lock_owner 0, busy 0.
  - request_ready reflects IDLE arbitration only after reset_in deasserts.
- Reset asserted mid-burst drops the lock and all outstanding reads; no response is produced for them.
- **Pipeline timing:**
  - Word accepted in cycle t appears on current_tensor_core_instruction in cycle t+1.
  - Its response appears in cycle t+1+READ_LATENCY.
  - Back-to-back accepts are allowed every cycle; throughput is 1 word/cycle.
- Simultaneous valids in IDLE resolve in one cycle, with no idle cycle between bursts from different requesters.
- A single-word burst (last=1 on first word) never enters LOCKED.
- A response and a new accept for the same requester in the same cycle are independent and both occur.

## Test plan
- **Reset values:** reset_in pulse mid-cycle → all outputs 0 asynchronously; after release with no valids, bus = 16'h0000 and busy = 0.
- **Round-robin:**
  - Setup: NUM_REQUESTERS=3; req0, req1 and req2 all valid, single-word bursts 16'h0101, 16'h0201, 16'h0301.
  - Required: bus shows 0101, 0201, 0301, 0101 on consecutive cycles.
- **Burst lock:**
  - Stimulus: req0 issues a 3-word burst with last on word 3, and drops valid for one cycle after word 1; req1 is held valid throughout.
  - Required: bus shows w1, 0000, w2, w3, then req1's word. request_ready[1] stays low until word 3 is accepted.
- **Read routing:**
  - Stimulus: READ_LATENCY=2; req1 issues a word with expects_read=1 at cycle 10; the tensor core drives 8'hF6 at cycle 13.
  - Required: response_valid = 3'b010 and response_data = -10 at cycle 13 only.
- **Reset opcode flush:**
  - Stimulus: read issued at t, then 16'h0003 accepted at t+1, READ_LATENCY=2.
  - Required: no response_valid at t+3; busy = 0 by t+3.
- **Reset mid-burst:**
  - Stimulus: assert reset_in while req2 holds the lock with one read outstanding.
  - Required: lock_owner 0, no response for the dropped read, and req0 is granted first after release.
